// File: rtl/rc4_key_sequencer.sv
// RC4 key-search phase controller: init -> shuffle -> decrypt per key, S-memory mux.
// Optional per-phase watchdog enabled by defining SEQ_WATCHDOG_EN.
module rc4_key_sequencer #(
    parameter logic [23:0] KEY_LAST    = 24'h3FFFFF,
    parameter int          WDOG_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [23:0] key_first,
    output logic        init_start,
    output logic        shuf_start,
    output logic        dec_start,
    input  logic        init_finish,
    input  logic        shuf_finish,
    input  logic        dec_finish,
    input  logic        dec_valid,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  shuf_addr,
    input  logic [7:0]  dec_addr,
    input  logic [7:0]  init_data,
    input  logic [7:0]  shuf_data,
    input  logic [7:0]  dec_data,
    input  logic        init_wren,
    input  logic        shuf_wren,
    input  logic        dec_wren,
    output logic [7:0]  s_address,
    output logic [7:0]  s_data,
    output logic        s_wren,
    output logic [23:0] secret_key,
    output logic        busy,
    output logic        found,
    output logic        exhausted,
    output logic        wdog_err
);

    typedef enum logic [3:0] {
        IDLE, INIT_RUN, INIT_DROP, SHUF_RUN, SHUF_DROP,
        DEC_RUN, DEC_DROP, NEXT_KEY, FOUND, EXHAUSTED, ERROR
    } state_t;

    state_t      state, state_nx;
    logic [23:0] key_q, key_nx;
    logic        valid_q, valid_nx;
    logic        wdog_hit;

`ifdef SEQ_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        in_run;

    assign in_run   = (state == INIT_RUN) || (state == SHUF_RUN) || (state == DEC_RUN);
    assign wdog_hit = in_run && (wdog_cnt == 16'(WDOG_CYCLES - 1));

    // Any state change restarts the count, so each RUN phase starts at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wdog_cnt <= '0;
        else if (state_nx != state)
            wdog_cnt <= '0;
        else if (in_run)
            wdog_cnt <= wdog_cnt + 16'd1;
    end

    assign wdog_err = (state == ERROR);
`else
    assign wdog_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            key_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            key_q   <= key_nx;
            valid_q <= valid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        key_nx   = key_q;
        valid_nx = valid_q;
        unique case (state)
            IDLE, FOUND, EXHAUSTED, ERROR: begin
                if (go) begin
                    key_nx   = key_first;
                    valid_nx = 1'b0;
                    state_nx = INIT_RUN;
                end
            end
            INIT_RUN: begin
                if (init_finish)
                    state_nx = INIT_DROP;
                else if (wdog_hit)
                    state_nx = ERROR;
            end
            INIT_DROP: state_nx = SHUF_RUN;
            SHUF_RUN: begin
                if (shuf_finish)
                    state_nx = SHUF_DROP;
                else if (wdog_hit)
                    state_nx = ERROR;
            end
            SHUF_DROP: state_nx = DEC_RUN;
            DEC_RUN: begin
                if (dec_finish) begin
                    valid_nx = dec_valid;
                    state_nx = DEC_DROP;
                end else if (wdog_hit) begin
                    state_nx = ERROR;
                end
            end
            DEC_DROP: state_nx = valid_q ? FOUND : NEXT_KEY;
            NEXT_KEY: begin
                // A start key beyond the limit still gets exactly one attempt.
                if (key_q >= KEY_LAST) begin
                    state_nx = EXHAUSTED;
                end else begin
                    key_nx   = key_q + 24'd1;
                    state_nx = INIT_RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_address = 8'h00;
        s_data    = 8'h00;
        s_wren    = 1'b0;
        unique case (state)
            INIT_RUN: begin
                s_address = init_addr;
                s_data    = init_data;
                s_wren    = init_wren;
            end
            SHUF_RUN: begin
                s_address = shuf_addr;
                s_data    = shuf_data;
                s_wren    = shuf_wren;
            end
            DEC_RUN: begin
                s_address = dec_addr;
                s_data    = dec_data;
                s_wren    = dec_wren;
            end
            default: ;
        endcase
    end

    assign init_start = (state == INIT_RUN);
    assign shuf_start = (state == SHUF_RUN);
    assign dec_start  = (state == DEC_RUN);
    assign secret_key = key_q;
    assign busy       = (state == INIT_RUN) || (state == INIT_DROP) ||
                        (state == SHUF_RUN) || (state == SHUF_DROP) ||
                        (state == DEC_RUN)  || (state == DEC_DROP)  ||
                        (state == NEXT_KEY);
    assign found      = (state == FOUND);
    assign exhausted  = (state == EXHAUSTED);

endmodule
